// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared state/command encodings and press-priority helper for key_entry_ctrl.
package key_entry_pkg;
  localparam int MAX_KEYS = 8;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, PRESENT} state_t;
  typedef enum logic [2:0] {NONE, DIGIT, BKSP, CLEAR, COMMIT} cmd_t;
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;
  function automatic pick_t lowest_press(input logic [MAX_KEYS-1:0] p);
    pick_t r;
    r = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--)
      if (p[i]) begin
        r.vld = 1'b1;
        r.idx = 3'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/key_entry_ctrl_debounce.sv
// key_debounce: 2-flop synchroniser plus counting debouncer; one-cycle press pulse on accepted fall.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          done;
  assign done  = cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign press = stable & ~sync[1] & done;
  // cnt counts consecutive samples that disagree with the debounced level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync   <= {sync[0], key};
      stable <= (sync[1] != stable && done) ? sync[1] : stable;
      cnt    <= (sync[1] == stable || done) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: debounced push-button BCD code entry with commit handshake.
// Optional idle timeout enabled by defining KEY_ENTRY_TIMEOUT_EN.
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic [NKEYS-1:0]             KEY,
  input  logic                         SW_MOD,
  output logic [4*DIGITS-1:0]          code,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         code_valid,
  input  logic                         code_ready,
  output logic                         err
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  logic [NKEYS-1:0] press;
  pick_t            pick;
  cmd_t             cmd;
  logic [3:0]       digit;
  state_t           state, state_n;
  logic [DW-1:0]    code_n;
  logic [CW-1:0]    count_n;
  logic             err_n;
  logic             timeout;
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (CLOCK_50),
      .rst  (RESET),
      .key  (KEY[k]),
      .press(press[k])
    );
  end
  always_comb begin
    pick  = lowest_press(MAX_KEYS'(press));
    digit = 4'(NKEYS) - 4'(pick.idx);
    cmd   = !pick.vld ? NONE
          : SW_MOD ? (pick.idx == 3'(NKEYS - 1) ? COMMIT : pick.idx == 3'd0 ? CLEAR : NONE)
          : (pick.idx == 3'd0 ? BKSP : DIGIT);
  end
`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle;
  logic          busy;
  assign busy    = state == ENTRY || state == FULL;
  assign timeout = busy && !pick.vld && idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) idle <= '0;
    else idle <= (pick.vld || !busy || timeout) ? '0 : idle + TW'(1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      state <= EMPTY;
      code  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      code  <= code_n;
      count <= count_n;
      err   <= err_n;
    end
  always_comb begin
    state_n = state;
    code_n  = code;
    count_n = count;
    err_n   = 1'b0;
    if (state == PRESENT) begin
      if (code_ready) begin
        state_n = EMPTY;
        code_n  = '0;
        count_n = '0;
      end
    end else begin
      case (cmd)
        DIGIT:
          if (state == FULL) err_n = 1'b1;
          else begin
            code_n  = (code << 4) | DW'(digit);
            count_n = count + CW'(1);
          end
        BKSP:
          if (state == EMPTY) err_n = 1'b1;
          else begin
            code_n  = code >> 4;
            count_n = count - CW'(1);
          end
        CLEAR: begin
          code_n  = '0;
          count_n = '0;
        end
        COMMIT: err_n = state == EMPTY;
        default: ;
      endcase
      // outside PRESENT the state is a pure function of the digit count
      state_n = (cmd == COMMIT && state != EMPTY) ? PRESENT
              : count_n == '0 ? EMPTY
              : count_n == CW'(DIGITS) ? FULL : ENTRY;
      if (timeout) begin
        state_n = EMPTY;
        code_n  = '0;
        count_n = '0;
      end
    end
  end
  always_comb code_valid = state == PRESENT;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: directed self-checking bench for key_entry_ctrl (DIGITS=4, NKEYS=4, DEBOUNCE_CYCLES=4).
module tb_key_entry_ctrl;
  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic        SW_MOD = 1'b0;
  logic        code_ready = 1'b0;
  logic [15:0] code;
  logic [2:0]  count;
  logic        code_valid;
  logic        err;
  int n_checks = 0, n_errors = 0, err_cnt = 0, e0 = 0;

  key_entry_ctrl #(
    .DIGITS(4), .NKEYS(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .KEY       (KEY),
    .SW_MOD    (SW_MOD),
    .code      (code),
    .count     (count),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .err       (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) if (err) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input int k, input logic mod);
    @(negedge CLOCK_50);
    SW_MOD = mod;
    KEY[k] = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    KEY[k] = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    SW_MOD = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    check("rst_code", code, 0);
    check("rst_count", count, 0);
    check("rst_valid", code_valid, 0);
    check("rst_err", err, 0);
    // enter 1,2,1,3 and commit
    press(3, 0); press(2, 0); press(3, 0); press(1, 0);
    check("entry_code", code, 16'h1213);
    check("entry_count", count, 4);
    press(3, 1);
    check("commit_valid", code_valid, 1);
    check("commit_code", code, 16'h1213);
    check("commit_count", count, 4);
    code_ready = 1'b1;
    @(negedge CLOCK_50);
    code_ready = 1'b0;
    check("accept_valid", code_valid, 0);
    check("accept_code", code, 0);
    check("accept_count", count, 0);
    // digit in FULL, then backspace
    press(3, 0); press(2, 0); press(1, 0); press(3, 0);
    check("full_code", code, 16'h1231);
    e0 = err_cnt;
    press(3, 0);
    check("full_err", err_cnt - e0, 1);
    check("full_hold", code, 16'h1231);
    check("full_count", count, 4);
    press(0, 0);
    check("bksp_code", code, 16'h0123);
    check("bksp_count", count, 3);
    code_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    code_ready = 1'b0;
    check("idle_ready", {13'd0, count, code}, {13'd0, 3'd3, 16'h0123});
    press(0, 1);
    check("clear_code", code, 0);
    check("clear_count", count, 0);
    e0 = err_cnt;
    press(0, 0);
    press(3, 1);
    check("empty_errs", err_cnt - e0, 2);
    check("empty_count", count, 0);
    check("empty_valid", code_valid, 0);
    // bounce rejection on KEY2
    repeat (10) begin
      KEY[2] = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      KEY[2] = 1'b1;
      @(negedge CLOCK_50);
    end
    repeat (8) @(negedge CLOCK_50);
    check("bounce_count", count, 0);
    KEY[2] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    KEY[2] = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("stable_count", count, 1);
    check("stable_code", code, 16'h0002);
    // simultaneous KEY1 + KEY3
    press(0, 1);
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    KEY[3] = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    KEY = 4'hF;
    repeat (8) @(negedge CLOCK_50);
    check("simul_count", count, 1);
    check("simul_code", code, 16'h0003);
    // frozen while presented
    press(0, 1);
    press(3, 0); press(2, 0);
    press(3, 1);
    check("present_valid", code_valid, 1);
    e0 = err_cnt;
    press(2, 0);
    check("frozen_code", code, 16'h0012);
    check("frozen_count", count, 2);
    check("frozen_err", err_cnt - e0, 0);
    code_ready = 1'b1;
    @(negedge CLOCK_50);
    code_ready = 1'b0;
    check("frozen_accept", code_valid, 0);
    // asynchronous reset mid-entry
    press(3, 0);
    check("pre_rst_count", count, 1);
    @(negedge CLOCK_50);
    #2 RESET = 1'b1;
    #1;
    check("arst_code", code, 0);
    check("arst_count", count, 0);
    check("arst_valid", code_valid, 0);
    check("arst_err", err, 0);
    // key held across reset release: accepted on the 6th edge
    KEY[3] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("held_early", count, 0);
    @(negedge CLOCK_50);
    check("held_count", count, 1);
    check("held_code", code, 16'h0001);
    KEY[3] = 1'b1;
    e0 = err_cnt;
    repeat (60) @(negedge CLOCK_50);
`ifdef KEY_ENTRY_TIMEOUT_EN
    check("timeout_count", count, 0);
    check("timeout_code", code, 0);
`else
    check("persist_count", count, 1);
    check("persist_code", code, 16'h0001);
`endif
    check("idle_err", err_cnt - e0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
